// File: rtl/junction_pkg.sv
// -----------------------------------------------------------------------------
// junction_pkg
// Shared definitions for the four-road junction scheduler:
//   - light output codes (LT_*)
//   - decoded congestion levels (RD_*), kept in thermometer form
//   - controller phase encoding (ST_*)
//   - decode_level(): maps a raw 3-bit sensor word to its level using the
//     highest set bit, so non-thermometer words still decode sensibly.
// -----------------------------------------------------------------------------
package junction_pkg;

  localparam int NUM_ROADS = 4;

  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_YELLOW = 2'b01,
    LT_GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    RD_EMPTY = 3'd0,
    RD_LESS  = 3'd1,
    RD_MORE  = 3'd3,
    RD_FULL  = 3'd7
  } level_t;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  function automatic level_t decode_level(input logic [2:0] s);
    if (s[2]) return RD_FULL;
    if (s[1]) return RD_MORE;
    if (s[0]) return RD_LESS;
    return RD_EMPTY;
  endfunction

endpackage

// File: rtl/road_select.sv
// -----------------------------------------------------------------------------
// road_select
// Purely combinational choice of the next road to receive right-of-way.
// Candidates are the three roads other than 'last', visited in round-robin
// order starting at last+1.
//   levels       in  12      decoded level per road, 3 bits each (road1 = [2:0])
//   skips        in  4*SW    skip count per road, SW bits each
//   last         in  2       index (0..3) of the road served most recently
//   chosen       out 2       index of the selected road
//   chosen_level out 3       decoded level of the selected road
// -----------------------------------------------------------------------------
module road_select
  import junction_pkg::*;
#(
  parameter int MAX_SKIP = 3,
  parameter int SW       = 2
) (
  input  logic [11:0]     levels,
  input  logic [4*SW-1:0] skips,
  input  logic [1:0]      last,
  output logic [1:0]      chosen,
  output logic [2:0]      chosen_level
);

  logic [3:0] score;
  logic [3:0] best;
  logic [1:0] idx;
  logic [2:0] lvl;
  logic       forced;

  // A starved (forced) road scores above every level, and all forced roads
  // score alike so that the round-robin order alone settles ties between
  // them. A strict '>' keeps the earliest candidate on equal scores; when
  // everything is empty nothing beats the default of last+1.
  always_comb begin
    chosen       = last + 2'd1;
    chosen_level = levels[3*int'(last + 2'd1) +: 3];
    best         = '0;
    score        = '0;
    idx          = '0;
    lvl          = '0;
    forced       = 1'b0;
    for (int k = 1; k < NUM_ROADS; k++) begin
      idx    = last + 2'(k);
      lvl    = levels[3*int'(idx) +: 3];
      forced = (lvl != RD_EMPTY) && (skips[SW*int'(idx) +: SW] >= SW'(MAX_SKIP));
      score  = forced ? 4'b1000 : {1'b0, lvl};
      if (score > best) begin
        best         = score;
        chosen       = idx;
        chosen_level = lvl;
      end
    end
  end

endmodule

// File: rtl/junction_phase_scheduler.sv
// -----------------------------------------------------------------------------
// junction_phase_scheduler
// Four-road junction controller. Each phase runs GREEN -> YELLOW -> ALL_RED;
// on ALL_RED expiry the next road is chosen and its green time is sized from
// its congestion level. All timing advances only on 'tick'.
//   clock       in  1   system clock, rising edge
//   clear       in  1   asynchronous active-low reset
//   tick        in  1   timebase enable
//   S1..S4      in  3   congestion sensors (000/001/011/111)
//   T1..T4      out 2   lights: 00 red, 01 yellow, 10 green
//   T           out 4   one-hot road holding right-of-way, 0 in ALL_RED
//   phase_done  out 1   one-cycle pulse on the edge leaving YELLOW
// -----------------------------------------------------------------------------
module junction_phase_scheduler
  import junction_pkg::*;
#(
  parameter int GREEN_EMPTY  = 2,
  parameter int GREEN_LESS   = 4,
  parameter int GREEN_MORE   = 6,
  parameter int GREEN_FULL   = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int MAX_SKIP     = 3
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic [2:0] S1,
  input  logic [2:0] S2,
  input  logic [2:0] S3,
  input  logic [2:0] S4,
  output logic [1:0] T1,
  output logic [1:0] T2,
  output logic [1:0] T3,
  output logic [1:0] T4,
  output logic [3:0] T,
  output logic       phase_done
);

  localparam int CW = 8;                      // phase and elapsed counters
  localparam int SW = $clog2(MAX_SKIP + 1);   // per-road skip counter

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   elapsed;
  logic [1:0]      last;
  logic [4*SW-1:0] skip;
  logic [4*SW-1:0] skip_next;
  logic [7:0]      lights;
  logic [3:0]      row;

  logic [2:0]      sense [NUM_ROADS];
  logic [11:0]     levels;
  logic [1:0]      sel_road;
  logic [2:0]      sel_level;
  logic            early_stop;

  assign sense[0] = S1;
  assign sense[1] = S2;
  assign sense[2] = S3;
  assign sense[3] = S4;

  generate
    for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_decode
      assign levels[3*gi +: 3] = decode_level(sense[gi]);
    end
  endgenerate

  road_select #(
    .MAX_SKIP (MAX_SKIP),
    .SW       (SW)
  ) u_select (
    .levels       (levels),
    .skips        (skip),
    .last         (last),
    .chosen       (sel_road),
    .chosen_level (sel_level)
  );

  function automatic logic [CW-1:0] green_ticks(input logic [2:0] lvl);
    case (lvl)
      RD_FULL: return CW'(GREEN_FULL);
      RD_MORE: return CW'(GREEN_MORE);
      RD_LESS: return CW'(GREEN_LESS);
      default: return CW'(GREEN_EMPTY);
    endcase
  endfunction

  function automatic logic [7:0] light_vec(input logic [1:0] road, input logic [1:0] code);
    logic [7:0] v;
    v = '0;
    v[2*road +: 2] = code;
    return v;
  endfunction

  // Skip bookkeeping applied together with a selection. The road served
  // just before (last) is not a candidate and keeps its count.
  always_comb begin
    skip_next = skip;
    for (int r = 0; r < NUM_ROADS; r++) begin
      if (2'(r) != last) begin
        if (2'(r) == sel_road || levels[3*r +: 3] == RD_EMPTY)
          skip_next[SW*r +: SW] = '0;
        else if (skip[SW*r +: SW] < SW'(MAX_SKIP))
          skip_next[SW*r +: SW] = skip[SW*r +: SW] + SW'(1);
      end
    end
  end

  // The served road has drained and has had its minimum green, counting
  // the tick being taken now.
  assign early_stop = (levels[3*int'(last) +: 3] == RD_EMPTY) &&
                      ((elapsed + CW'(1)) >= CW'(GREEN_EMPTY));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= ST_ALLRED;
      cnt        <= CW'(ALLRED_TICKS);
      last       <= 2'd3;
      skip       <= '0;
      elapsed    <= '0;
      lights     <= '0;
      row        <= '0;
      phase_done <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      if (tick) begin
        case (state)
          ST_ALLRED: begin
            if (cnt == CW'(1)) begin
              state   <= ST_GREEN;
              cnt     <= green_ticks(sel_level);
              last    <= sel_road;
              elapsed <= '0;
              skip    <= skip_next;
              lights  <= light_vec(sel_road, LT_GREEN);
              row     <= 4'b0001 << sel_road;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_GREEN: begin
            elapsed <= elapsed + CW'(1);
            if (early_stop || cnt == CW'(1)) begin
              state  <= ST_YELLOW;
              cnt    <= CW'(YELLOW_TICKS);
              lights <= light_vec(last, LT_YELLOW);
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_YELLOW: begin
            if (cnt == CW'(1)) begin
              state      <= ST_ALLRED;
              cnt        <= CW'(ALLRED_TICKS);
              lights     <= '0;
              row        <= '0;
              phase_done <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            state  <= ST_ALLRED;
            cnt    <= CW'(ALLRED_TICKS);
            lights <= '0;
            row    <= '0;
          end
        endcase
      end
    end
  end

  assign T1 = lights[1:0];
  assign T2 = lights[3:2];
  assign T3 = lights[5:4];
  assign T4 = lights[7:6];
  assign T  = row;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_junction_phase_scheduler
// Directed scenarios with hand-computed served-road / green-length
// expectations, plus a behavioural model of the junction that is checked
// against the outputs after every clock edge.
// -----------------------------------------------------------------------------
module tb_junction_phase_scheduler;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       tick  = 1'b0;
  logic [2:0] S1 = '0, S2 = '0, S3 = '0, S4 = '0;
  logic [1:0] T1, T2, T3, T4;
  logic [3:0] T;
  logic       phase_done;

  int errors = 0;
  int checks = 0;

  junction_phase_scheduler dut (
    .clock      (clock),
    .clear      (clear),
    .tick       (tick),
    .S1         (S1),
    .S2         (S2),
    .S3         (S3),
    .S4         (S4),
    .T1         (T1),
    .T2         (T2),
    .T3         (T3),
    .T4         (T4),
    .T          (T),
    .phase_done (phase_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 all-red, 1 green, 2 yellow; 'left' = ticks still to run.
  int m_phase, m_left, m_last, m_elapsed;
  int m_skip [4];
  bit m_pd;

  function automatic logic [2:0] sensor(input int r);
    case (r)
      0: return S1;
      1: return S2;
      2: return S3;
      default: return S4;
    endcase
  endfunction

  // 0 empty, 1 less, 2 more, 3 full; green time is 2*(rank+1)
  function automatic int rank_of(input logic [2:0] s);
    if (s[2]) return 3;
    if (s[1]) return 2;
    if (s[0]) return 1;
    return 0;
  endfunction

  function automatic int pick_next();
    int r, best, best_rank;
    for (int k = 1; k <= 3; k++) begin
      r = (m_last + k) % 4;
      if (rank_of(sensor(r)) > 0 && m_skip[r] >= 3) return r;
    end
    best = -1;
    best_rank = -1;
    for (int k = 1; k <= 3; k++) begin
      r = (m_last + k) % 4;
      if (rank_of(sensor(r)) > best_rank) begin
        best_rank = rank_of(sensor(r));
        best = r;
      end
    end
    if (best_rank == 0) return (m_last + 1) % 4;
    return best;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 1; m_last = 3; m_elapsed = 0; m_pd = 0;
    for (int r = 0; r < 4; r++) m_skip[r] = 0;
  endtask

  task automatic model_step();
    int c, r;
    m_pd = 0;
    if (tick) begin
      m_left--;
      case (m_phase)
        0: if (m_left == 0) begin
          c = pick_next();
          for (int k = 1; k <= 3; k++) begin
            r = (m_last + k) % 4;
            if (r == c || rank_of(sensor(r)) == 0) m_skip[r] = 0;
            else if (m_skip[r] < 3) m_skip[r]++;
          end
          m_last = c;
          m_left = 2 * (rank_of(sensor(c)) + 1);
          m_elapsed = 0;
          m_phase = 1;
        end
        1: begin
          m_elapsed++;
          if (m_left == 0 || (rank_of(sensor(m_last)) == 0 && m_elapsed >= 2)) begin
            m_phase = 2;
            m_left = 2;
          end
        end
        default: if (m_left == 0) begin
          m_phase = 0;
          m_left = 1;
          m_pd = 1;
        end
      endcase
    end
  endtask

  // ---------------- served-green log ----------------
  int served_q [$];
  int len_q [$];
  int cur_green = -1;
  int run = 0;

  always @(negedge clear) model_reset();

  always @(posedge clock) begin
    logic [7:0] exp_l, got_l;
    logic [3:0] exp_t;
    int g;
    if (!clear) model_reset();
    else model_step();
    #1;
    exp_l = '0;
    exp_t = '0;
    if (m_phase != 0) begin
      exp_t = 4'(1 << m_last);
      exp_l[2*m_last +: 2] = (m_phase == 1) ? 2'b10 : 2'b01;
    end
    got_l = {T4, T3, T2, T1};
    checks++;
    if (got_l !== exp_l || T !== exp_t || phase_done !== m_pd) begin
      errors++;
      $display("FAIL outputs t=%0t: got lights=%b T=%b pd=%b expected lights=%b T=%b pd=%b",
               $time, got_l, T, phase_done, exp_l, exp_t, m_pd);
    end
    g = -1;
    for (int r = 0; r < 4; r++) if (got_l[2*r +: 2] == 2'b10) g = r;
    if (g != cur_green) begin
      if (cur_green != -1) begin
        served_q.push_back(cur_green + 1);
        len_q.push_back(run);
        $display("green road %0d for %0d cycles", cur_green + 1, run);
      end
      cur_green = g;
      run = (g != -1) ? 1 : 0;
    end else if (g != -1) begin
      run++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_s(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    S1 = a; S2 = b; S3 = c; S4 = d;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0;
    tick  = 1'b1;
    repeat (3) @(negedge clock) tick = ~tick;
    chk("reset_outputs", {T, T4, T3, T2, T1, phase_done}, 0);
    served_q.delete();
    len_q.delete();
    cur_green = -1;
    run = 0;
    clear = 1'b1;
    tick  = 1'b1;
  endtask

  task automatic wait_served(input int n, input int budget, input string name);
    int cyc = 0;
    while (served_q.size() < n && cyc < budget) begin
      @(posedge clock);
      #2;
      cyc++;
    end
    chk(name, int'(served_q.size() >= n), 1);
  endtask

  task automatic check_entry(input string name, input int i, input int road, input int len);
    int ar, al;
    ar = (i < served_q.size()) ? served_q[i] : -1;
    al = (i < len_q.size()) ? len_q[i] : -1;
    chk($sformatf("%s_road[%0d]", name, i), ar, road);
    chk($sformatf("%s_len[%0d]", name, i), al, len);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int cyc;

    // All MORE: round robin 1,2,3,4,1 with 6-tick greens
    set_s(3'b011, 3'b011, 3'b011, 3'b011);
    do_reset();
    @(posedge clock); #1;
    chk("first_green_T", T, 4'b0001);
    chk("first_green_T1", T1, 2'b10);
    wait_served(5, 200, "A_wait");
    for (int i = 0; i < 5; i++) check_entry("A", i, (i % 4) + 1, 6);

    // FULL road1 then MORE road2 (road1 excluded, tie from road2)
    set_s(3'b111, 3'b011, 3'b011, 3'b011);
    do_reset();
    wait_served(2, 100, "B_wait");
    check_entry("B", 0, 1, 8);
    check_entry("B", 1, 2, 6);

    // Starvation: road3 forced after being skipped three times
    set_s(3'b111, 3'b111, 3'b001, 3'b000);
    do_reset();
    wait_served(4, 200, "C_wait");
    check_entry("C", 0, 1, 8);
    check_entry("C", 1, 2, 8);
    check_entry("C", 2, 1, 8);
    check_entry("C", 3, 3, 4);

    // Early termination after elapsed=3
    set_s(3'b111, 3'b000, 3'b000, 3'b000);
    do_reset();
    repeat (4) @(posedge clock);
    @(negedge clock) S1 = 3'b000;
    wait_served(1, 50, "D1_wait");
    check_entry("D1", 0, 1, 4);

    // Early termination requested at elapsed=0: minimum green
    set_s(3'b111, 3'b000, 3'b000, 3'b000);
    do_reset();
    @(posedge clock);
    @(negedge clock) S1 = 3'b000;
    wait_served(1, 50, "D2_wait");
    check_entry("D2", 0, 1, 2);

    // tick gating mid-yellow
    set_s(3'b011, 3'b011, 3'b011, 3'b011);
    do_reset();
    cyc = 0;
    while (T1 != 2'b01 && cyc < 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("E_reach_yellow", T1, 2'b01);
    @(negedge clock) tick = 1'b0;
    repeat (20) @(negedge clock);
    chk("E_frozen_T1", T1, 2'b01);
    chk("E_frozen_T", T, 4'b0001);
    tick = 1'b1;
    @(posedge clock); #1;
    chk("E_yellow_second", T1, 2'b01);
    @(posedge clock); #1;
    chk("E_allred_T", T, 4'b0000);
    chk("E_pulse", phase_done, 1);
    @(posedge clock); #1;
    chk("E_pulse_end", phase_done, 0);
    chk("E_next_road2", T, 4'b0010);

    // Odd sensor code 100 decodes FULL
    set_s(3'b000, 3'b000, 3'b000, 3'b000);
    do_reset();
    @(posedge clock);
    @(negedge clock) S2 = 3'b100;
    wait_served(2, 60, "odd_wait");
    check_entry("odd", 0, 1, 2);
    check_entry("odd", 1, 2, 8);

    // Asynchronous reset mid-green, no clock edge needed
    set_s(3'b011, 3'b011, 3'b011, 3'b011);
    do_reset();
    repeat (3) @(posedge clock);
    #2;
    chk("G_before_T", T, 4'b0001);
    clear = 1'b0;
    #1;
    chk("G_async_clear", {T, T4, T3, T2, T1, phase_done}, 0);

    // Irregular ticks and changing (including odd) sensor codes
    set_s(3'b111, 3'b001, 3'b000, 3'b011);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      tick = 1'($urandom_range(0, 1));
      if (c % 23 == 0) begin
        S1 = 3'($urandom_range(0, 7));
        S2 = 3'($urandom_range(0, 7));
        S3 = 3'($urandom_range(0, 7));
        S4 = 3'($urandom_range(0, 7));
      end
    end
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
